// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl_if
// Description : Bundle between the fetch-stage sequencer and its neighbours
//               (hazard/branch logic on the input side, imem port on the
//               output side).
//               slave  - the fetch controller itself
//               master - the surrounding pipeline / memory environment
//   ihit           : imem read done, instruction valid for current pc
//   stall          : downstream cannot accept an instruction this cycle
//   redirect_valid : branch/jump taken, redirect_pc is the new target
//   redirect_pc    : redirect target address
//   halt_in        : halt resolved, stop fetching permanently
//   pc             : current fetch address (registered)
//   iren           : imem read enable
//   fetch_valid    : instruction at pc accepted downstream this cycle
//   squash         : imem data returned this cycle is discarded
//   halted         : controller is halted
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_ctrl_if;
    logic        ihit;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_in;
    logic [31:0] pc;
    logic        iren;
    logic        fetch_valid;
    logic        squash;
    logic        halted;

    modport slave (
        input  ihit, stall, redirect_valid, redirect_pc, halt_in,
        output pc, iren, fetch_valid, squash, halted
    );

    modport master (
        output ihit, stall, redirect_valid, redirect_pc, halt_in,
        input  pc, iren, fetch_valid, squash, halted
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Fetch-stage sequencer. Owns the program counter and the imem
//               read handshake; each cycle the pc advances, redirects, holds
//               or freezes. pc only moves on a cycle with ihit so the imem
//               address is stable while an access is outstanding.
// Ports       : clk   - system clock, all state on posedge
//               rst   - asynchronous reset, active-high
//               fetch - pc_fetch_ctrl_if.slave (handshake and pc outputs)
// Parameters  : PC_INIT - pc value loaded on reset
//               PC_STEP - byte increment per sequential fetch
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned PC_STEP = 4
) (
    input  wire             clk,
    input  wire             rst,
    pc_fetch_ctrl_if.slave  fetch
);

    localparam logic [31:0] c_STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        ST_FETCH      = 2'd0,
        ST_REDIR_PEND = 2'd1,
        ST_HALTED     = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_pend_pc;
    logic [31:0] w_pend_nxt;
    logic        w_fetch_valid;
    logic        w_squash;
    logic [31:0] w_redir_aligned;

    // Targets are always word aligned, whatever the branch unit hands us.
    assign w_redir_aligned = {fetch.redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_pc      <= PC_INIT;
            r_pend_pc <= 32'h0000_0000;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pend_pc <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pend_nxt    = r_pend_pc;
        w_fetch_valid = 1'b0;
        w_squash      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (fetch.halt_in) begin
                    w_state_nxt = ST_HALTED;
                end else if (fetch.redirect_valid) begin
                    if (fetch.ihit) begin
                        // The instruction just returned is on the wrong path.
                        w_pc_nxt = w_redir_aligned;
                        w_squash = 1'b1;
                    end else begin
                        // Access still in flight: keep pc stable until it lands.
                        w_pend_nxt  = w_redir_aligned;
                        w_state_nxt = ST_REDIR_PEND;
                    end
                end else if (fetch.ihit && !fetch.stall) begin
                    w_fetch_valid = 1'b1;
                    w_pc_nxt      = r_pc + c_STEP;
                end
            end
            ST_REDIR_PEND: begin
                if (fetch.halt_in) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    if (fetch.redirect_valid) begin
                        w_pend_nxt = w_redir_aligned;
                    end
                    if (fetch.ihit) begin
                        // A redirect arriving with the ihit is younger than pend_pc.
                        w_squash    = 1'b1;
                        w_pc_nxt    = fetch.redirect_valid ? w_redir_aligned : r_pend_pc;
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // Strobes are suppressed while reset is held so nothing downstream
    // consumes an instruction during reset.
    assign fetch.pc          = r_pc;
    assign fetch.iren        = (r_state != ST_HALTED);
    assign fetch.fetch_valid = w_fetch_valid & ~rst;
    assign fetch.squash      = w_squash & ~rst;
    assign fetch.halted      = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_ctrl
// Description : Self-checking bench for pc_fetch_ctrl. A behavioural model of
//               the fetch rules predicts every output each cycle; directed
//               sequences with literal expectations are followed by a
//               randomized run with occasional resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    localparam logic [31:0] c_PC_INIT = 32'h0000_0000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(
        .PC_INIT (c_PC_INIT),
        .PC_STEP (4)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .fetch (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_waiting;   // a redirect is parked behind an in-flight access
    bit          m_halt;

    task automatic model_reset();
        m_pc      = c_PC_INIT;
        m_pend    = 32'h0;
        m_waiting = 1'b0;
        m_halt    = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against what the model says for the current inputs.
    task automatic compare_all();
        bit active;
        bit e_fv;
        bit e_sq;
        active = !rst && !m_halt && !bus.halt_in;
        e_fv   = active && !m_waiting && !bus.redirect_valid && bus.ihit && !bus.stall;
        e_sq   = active && bus.ihit && (m_waiting || bus.redirect_valid);
        chk("pc",          bus.pc,          m_pc);
        chk("iren",        32'(bus.iren),        32'(!m_halt));
        chk("halted",      32'(bus.halted),      32'(m_halt));
        chk("fetch_valid", 32'(bus.fetch_valid), 32'(e_fv));
        chk("squash",      32'(bus.squash),      32'(e_sq));
        chk("fv_sq_excl",  32'(bus.fetch_valid & bus.squash), 32'h0);
    endtask

    // Apply the rules for the inputs of this cycle to get next-cycle state.
    task automatic model_step();
        logic [31:0] tgt;
        tgt = bus.redirect_pc & 32'hFFFF_FFFC;
        if (m_halt) begin
            // frozen until reset
        end else if (bus.halt_in) begin
            m_halt    = 1'b1;
            m_waiting = 1'b0;
        end else if (m_waiting) begin
            if (bus.redirect_valid) m_pend = tgt;
            if (bus.ihit) begin
                m_pc      = m_pend;
                m_waiting = 1'b0;
            end
        end else if (bus.redirect_valid) begin
            if (bus.ihit) m_pc = tgt;
            else begin
                m_pend    = tgt;
                m_waiting = 1'b1;
            end
        end else if (bus.ihit && !bus.stall) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic cyc(input bit ih, input bit st, input bit rv,
                       input logic [31:0] rp, input bit h);
        @(posedge clk);
        #1;
        bus.ihit           = ih;
        bus.stall          = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.halt_in        = h;
        #1;
        compare_all();
        model_step();
    endtask

    // Assert reset mid-cycle (asynchronous), check, release after a posedge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        bus.ihit = 1'b1; bus.stall = 1'b0; bus.redirect_valid = 1'b0;
        bus.halt_in = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("rst_pc_lit", bus.pc, c_PC_INIT);
        chk("rst_fv_lit", 32'(bus.fetch_valid), 32'h0);
        chk("rst_iren_lit", 32'(bus.iren), 32'h1);
        @(posedge clk);
        #1;
        bus.ihit = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.ihit = 1'b0; bus.stall = 1'b0; bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0; bus.halt_in = 1'b0;
        model_reset();

        // 1: sequential fetch
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 32'h0, 0);
            chk("seq_pc_lit", bus.pc, 32'(i * 4));
            chk("seq_fv_lit", 32'(bus.fetch_valid), 32'h1);
        end

        // 2: stall at pc=8
        do_reset();
        cyc(1, 0, 0, 32'h0, 0);
        cyc(1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 32'h0, 0);
            chk("stall_pc_lit", bus.pc, 32'h8);
            chk("stall_fv_lit", 32'(bus.fetch_valid), 32'h0);
        end
        cyc(1, 0, 0, 32'h0, 0);
        chk("unstall_fv_lit", 32'(bus.fetch_valid), 32'h1);
        cyc(0, 0, 0, 32'h0, 0);
        chk("unstall_pc_lit", bus.pc, 32'hC);

        // 3: redirect while access outstanding at pc=8
        do_reset();
        cyc(1, 0, 0, 32'h0, 0);
        cyc(1, 0, 0, 32'h0, 0);
        cyc(0, 0, 1, 32'h40, 0);
        chk("rp_pc_hold_lit", bus.pc, 32'h8);
        cyc(0, 0, 0, 32'h0, 0);
        chk("rp_pc_hold2_lit", bus.pc, 32'h8);
        cyc(1, 0, 0, 32'h0, 0);
        chk("rp_squash_lit", 32'(bus.squash), 32'h1);
        chk("rp_fv_lit", 32'(bus.fetch_valid), 32'h0);
        cyc(0, 0, 0, 32'h0, 0);
        chk("rp_target_lit", bus.pc, 32'h40);

        // 4: youngest redirect wins; unaligned target
        cyc(0, 0, 1, 32'h43, 0);
        cyc(0, 0, 1, 32'h80, 0);
        cyc(1, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 0);
        chk("young_lit", bus.pc, 32'h80);
        cyc(1, 0, 1, 32'h43, 0);
        chk("redir_hit_sq_lit", 32'(bus.squash), 32'h1);
        cyc(0, 0, 0, 32'h0, 0);
        chk("align_lit", bus.pc, 32'h40);

        // 5: halt beats redirect and ihit
        cyc(1, 0, 1, 32'h100, 1);
        chk("halt_sq_lit", 32'(bus.squash), 32'h0);
        cyc(1, 0, 1, 32'h200, 0);
        chk("halt_pc_lit", bus.pc, 32'h40);
        chk("halt_iren_lit", 32'(bus.iren), 32'h0);
        chk("halt_flag_lit", 32'(bus.halted), 32'h1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 32'h0, 0);
        chk("halt_ignore_lit", bus.pc, 32'h40);
        do_reset();
        cyc(1, 0, 0, 32'h0, 0);
        chk("post_halt_fv_lit", 32'(bus.fetch_valid), 32'h1);

        // 6: wrap, then reset in the middle of a pending redirect
        cyc(1, 0, 1, 32'hFFFF_FFFC, 0);
        cyc(1, 0, 0, 32'h0, 0);
        chk("wrap_from_lit", bus.pc, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 32'h0, 0);
        chk("wrap_to_lit", bus.pc, 32'h0);
        cyc(1, 0, 0, 32'h0, 0);
        cyc(0, 0, 1, 32'h200, 0);
        do_reset();
        cyc(1, 0, 0, 32'h0, 0);
        chk("rst_pend_pc_lit", bus.pc, c_PC_INIT);
        chk("rst_pend_fv_lit", 32'(bus.fetch_valid), 32'h1);

        // randomized run
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                logic [31:0] rp;
                rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                 : $urandom;
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0, rp, $urandom_range(0, 149) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
